// File: rtl/wave_pkg.sv
// Shared definitions for the waveform capture path: FSM state encoding,
// frame and RAM geometry, and the sample-to-screen conversion.
package wave_pkg;

  typedef enum logic [1:0] {
    ARMED  = 2'd0,
    ACTIVE = 2'd1,
    WAIT   = 2'd2
  } wave_state_t;

  localparam int WAVE_SAMPLES = 256;
  localparam int WAVE_ADDR_W  = 9;
  localparam int WAVE_DATA_W  = 8;
  localparam int WAVE_OFF_W   = $clog2(WAVE_SAMPLES);

  // 127 - s for a signed byte s; positive peaks land near the top of screen.
  function automatic logic [WAVE_DATA_W-1:0] to_screen(input logic [7:0] s);
    return {s[7], ~s[6:0]};
  endfunction

endpackage

// File: rtl/zero_cross_det.sv
// Rising zero-crossing detector.
// Ports:
//   clk, reset   - system clock, async active-high reset
//   strobe       - sample valid this cycle
//   sample_sign  - sign bit of the current sample
//   rising       - combinational: previous sample negative, current one not
// The stored sign updates on every strobe regardless of controller state,
// and resets to 0 so the first sample after reset can never trigger.
module zero_cross_det
  import wave_pkg::*;
(
  input  logic clk,
  input  logic reset,
  input  logic strobe,
  input  logic sample_sign,
  output logic rising
);

  logic prev_neg;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      prev_neg <= 1'b0;
    end else if (strobe) begin
      prev_neg <= sample_sign;
    end
  end

  assign rising = strobe & prev_neg & ~sample_sign;

endmodule

// File: rtl/wave_buffer_ctrl.sv
// Write-side controller for the 512x8 double-buffered waveform RAM.
// Captures 256-sample frames starting at a rising zero crossing (or after
// TRIG_TIMEOUT samples without one) into the half the display is not
// reading, then flips read_index on the next vsync.
// Ports:
//   clk, reset     - system clock, async active-high reset
//   new_sample     - strobe, sample_in valid
//   sample_in      - signed 16-bit audio sample
//   vsync          - strobe, start of display frame
//   write_en       - registered RAM write strobe
//   write_address  - registered {~read_index, offset}
//   write_sample   - registered screen value
//   read_index     - half currently displayed
//   armed          - high while waiting for a trigger
//
// state  | meaning
// ARMED  | waiting for rising crossing or timeout; no writes
// ACTIVE | writing one sample per strobe at offsets 1..255
// WAIT   | frame complete, holding until vsync flips read_index
module wave_buffer_ctrl
  import wave_pkg::*;
#(
  parameter int TRIG_TIMEOUT = 1024
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   new_sample,
  input  logic [15:0]            sample_in,
  input  logic                   vsync,
  output logic                   write_en,
  output logic [WAVE_ADDR_W-1:0] write_address,
  output logic [WAVE_DATA_W-1:0] write_sample,
  output logic                   read_index,
  output logic                   armed
);

  localparam int TCNT_W = $clog2(TRIG_TIMEOUT + 1);
  localparam logic [TCNT_W-1:0] TCNT_LAST = TCNT_W'(TRIG_TIMEOUT - 1);

  wave_state_t           state_q, state_d;
  logic [WAVE_OFF_W-1:0] offset_q, offset_d;
  logic [WAVE_OFF_W-1:0] wr_off;
  logic [TCNT_W-1:0]     tcnt_q, tcnt_d;
  logic                  read_index_d;
  logic                  wr_d;
  logic                  rising;
  logic                  unused_low;

  assign unused_low = ^sample_in[7:0];

  zero_cross_det u_zc (
    .clk         (clk),
    .reset       (reset),
    .strobe      (new_sample),
    .sample_sign (sample_in[15]),
    .rising      (rising)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= ARMED;
      offset_q   <= '0;
      tcnt_q     <= '0;
      read_index <= 1'b0;
    end else begin
      state_q    <= state_d;
      offset_q   <= offset_d;
      tcnt_q     <= tcnt_d;
      read_index <= read_index_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    offset_d     = offset_q;
    tcnt_d       = tcnt_q;
    read_index_d = read_index;
    wr_d         = 1'b0;
    wr_off       = offset_q;
    unique case (state_q)
      ARMED: begin
        if (new_sample) begin
          if (rising || tcnt_q == TCNT_LAST) begin
            wr_d     = 1'b1;
            wr_off   = '0;
            offset_d = WAVE_OFF_W'(1);
            state_d  = ACTIVE;
          end else begin
            tcnt_d = tcnt_q + 1'b1;
          end
        end
      end
      ACTIVE: begin
        if (new_sample) begin
          wr_d     = 1'b1;
          offset_d = offset_q + 1'b1;
          if (offset_q == '1) begin
            state_d = WAIT;
          end
        end
      end
      WAIT: begin
        // A sample arriving with vsync is dropped: it is neither counted
        // nor considered as a trigger, only prev_neg sees it.
        if (vsync) begin
          read_index_d = ~read_index;
          tcnt_d       = '0;
          state_d      = ARMED;
        end
      end
      default: begin
        state_d = ARMED;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      write_en      <= 1'b0;
      write_address <= WAVE_ADDR_W'(9'h100);
      write_sample  <= '0;
    end else begin
      write_en <= wr_d;
      if (wr_d) begin
        write_address <= {~read_index, wr_off};
        write_sample  <= to_screen(sample_in[15:8]);
      end
    end
  end

  assign armed = (state_q == ARMED);

endmodule

// File: tb/tb_wave_buffer_ctrl.sv
module tb_wave_buffer_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        new_sample;
  logic [15:0] sample_in;
  logic        vsync;
  logic        write_en;
  logic [8:0]  write_address;
  logic [7:0]  write_sample;
  logic        read_index;
  logic        armed;

  int n_checks = 0;
  int n_errors = 0;
  logic [16:0] exp_q[$];

  wave_buffer_ctrl #(.TRIG_TIMEOUT(1024)) dut (
    .clk           (clk),
    .reset         (reset),
    .new_sample    (new_sample),
    .sample_in     (sample_in),
    .vsync         (vsync),
    .write_en      (write_en),
    .write_address (write_address),
    .write_sample  (write_sample),
    .read_index    (read_index),
    .armed         (armed)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Expected screen value computed arithmetically as 127 - signed(s).
  task automatic push_exp(input logic [8:0] addr, input logic [7:0] s);
    int v;
    v = 127 - int'($signed(s));
    exp_q.push_back({addr, 8'(v)});
  endtask

  task automatic send(input logic [7:0] s);
    sample_in  = {s, 8'($urandom)};
    new_sample = 1'b1;
    tick();
    new_sample = 1'b0;
  endtask

  task automatic pulse_vsync();
    vsync = 1'b1;
    tick();
    vsync = 1'b0;
  endtask

  always @(negedge clk) begin
    if (!reset && write_en) begin
      if (exp_q.size() == 0) begin
        chk("spurious_write", {23'd0, write_address}, 32'h1ff);
      end else begin
        logic [16:0] e;
        e = exp_q.pop_front();
        chk("wr_addr", {23'd0, write_address}, {23'd0, e[16:8]});
        chk("wr_data", {24'd0, write_sample}, {24'd0, e[7:0]});
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [7:0] s;
    reset      = 1'b1;
    new_sample = 1'b0;
    sample_in  = '0;
    vsync      = 1'b0;
    #3;
    chk("rst_write_en", write_en, 0);
    chk("rst_addr", write_address, 9'h100);
    chk("rst_data", write_sample, 0);
    chk("rst_read_index", read_index, 0);
    chk("rst_armed", armed, 1);
    tick();
    reset = 1'b0;
    tick();

    // First sample negative, then a rising crossing.
    send(8'h9C);
    chk("armed_after_neg", armed, 1);
    push_exp(9'h100, 8'd50);
    send(8'd50);
    chk("active_after_trig", armed, 0);
    for (int i = 1; i < 256; i++) begin
      if (i == 100) begin
        pulse_vsync();
        chk("vsync_active_ri", read_index, 0);
      end
      push_exp(9'(9'h100 + i), 8'd0);
      send(8'd0);
    end
    repeat (3) send(8'hFB);
    chk("wait_not_armed", armed, 0);
    chk("wait_ri", read_index, 0);

    // Flip, then capture into the lower half.
    pulse_vsync();
    chk("flip_ri", read_index, 1);
    chk("flip_armed", armed, 1);
    push_exp(9'h000, 8'd10);
    send(8'd10);
    for (int i = 1; i < 256; i++) begin
      s = (i == 255) ? 8'hC0 : 8'($urandom);
      push_exp(9'(i), s);
      send(s);
    end

    // vsync and sample together in WAIT: flip, sample dropped.
    vsync      = 1'b1;
    new_sample = 1'b1;
    sample_in  = {8'd30, 8'h00};
    tick();
    vsync      = 1'b0;
    new_sample = 1'b0;
    chk("combo_ri", read_index, 0);
    chk("combo_armed", armed, 1);

    // Timeout path with all-positive input.
    repeat (1023) send(8'd20);
    chk("timeout_1023_armed", armed, 1);
    push_exp(9'h100, 8'd20);
    send(8'd20);
    chk("timeout_trig_active", armed, 0);
    for (int i = 1; i < 256; i++) begin
      s = (i == 255) ? 8'hC0 : 8'(i * 5);
      push_exp(9'(9'h100 + i), s);
      send(s);
    end
    pulse_vsync();
    chk("flip2_ri", read_index, 1);
    send(8'hFF);
    push_exp(9'h000, 8'd5);
    send(8'd5);
    for (int i = 1; i < 130; i++) begin
      s = 8'(i * 3);
      push_exp(9'(i), s);
      send(s);
    end

    // Reset mid-capture at offset 130.
    @(negedge clk);
    #1;
    reset = 1'b1;
    #1;
    chk("midrst_ri", read_index, 0);
    chk("midrst_write_en", write_en, 0);
    chk("midrst_addr", write_address, 9'h100);
    chk("midrst_armed", armed, 1);
    tick();
    reset = 1'b0;
    chk("midrst_queue", 32'(exp_q.size()), 0);
    send(8'hFF);
    push_exp(9'h100, 8'd40);
    send(8'd40);
    repeat (3) tick();
    chk("queue_drained", 32'(exp_q.size()), 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/wave_buffer_ctrl.md
# wave_buffer_ctrl

Write-side controller for the 512x8 waveform RAM that feeds the oscilloscope display. It converts incoming audio samples to 8-bit screen values and captures 256-sample frames starting at a rising zero crossing, with a timeout fallback. Frames are written into the half of the RAM the display is not reading. On the next display frame strobe after a capture completes, it flips `read_index` so the display reads the new frame tear-free.

## Interface
Parameters:
- `TRIG_TIMEOUT`, 1024: accepted samples in ARMED after which a capture is forced without a zero crossing.

Ports:
- `clk` in 1: single system clock.
- `reset` in 1: asynchronous, active-high reset.
- `new_sample` in 1: one-cycle strobe; `sample_in` is valid this cycle.
- `sample_in` in 16: signed two's-complement audio sample.
- `vsync` in 1: one-cycle strobe, start of a display frame.
- `write_en` out 1: RAM write strobe, registered.
- `write_address` out 9: `{~read_index, offset[7:0]}`, registered.
- `write_sample` out 8: screen value, registered.
- `read_index` out 1: display buffer select; the display reads the half `read_index`.
- `armed` out 1: high while in ARMED.

## Operation
- States are ARMED, ACTIVE and WAIT. Reset state is ARMED.
- Conversion: `s = sample_in[15:8]`, `write_sample = 127 - s = {s[7], ~s[6:0]}`, range 0..255. Positive peaks map to small values (top of screen).
- `prev_neg` is updated to `sample_in[15]` on every accepted sample, in all states. Its reset value is 0, so the first sample after reset never triggers.
- In ARMED, on `new_sample`:
  - The sample triggers when `prev_neg==1 && sample_in[15]==0`, or when it is the `TRIG_TIMEOUT`-th sample counted in ARMED.
  - On trigger: write the sample at offset 0, set offset to 1, go to ACTIVE.
  - Otherwise: increment the timeout counter and write nothing.
  - The timeout counter clears on every entry to ARMED.
- In ACTIVE, each `new_sample` writes at the current offset, then the offset increments. The write at offset 255 moves the FSM to WAIT; the offset wraps to 0.
- In WAIT, `new_sample` is ignored (no write, `prev_neg` still updates). On `vsync`, toggle `read_index` and go to ARMED.
- `vsync` in ARMED or ACTIVE is ignored. The displayed half never changes mid-capture.
- `read_index` toggles only on WAIT→ARMED. Writes always target half `~read_index`, so the displayed half is never written.

## Timing
- Write latency: `new_sample` at cycle N → `write_en`=1 with matching address/data at cycle N+1, for exactly one cycle. Between writes `write_en`=0; address and data hold their last values.
- Triggering sample: state is ACTIVE at N+1. The 256th write occurs one cycle after the 256th accepted sample, and the state is WAIT in that same cycle.
- `vsync` at cycle M in WAIT → `read_index` toggled and state ARMED at M+1. `armed`=1 from M+1.
- `vsync` and `new_sample` in the same WAIT cycle: the flip happens and the sample is dropped. It is not counted toward the timeout and is not a trigger candidate, but it still updates `prev_neg`.
- `new_sample` on consecutive cycles is legal; one write per strobe, with no loss in ACTIVE.
- Reset values (async, immediate): state ARMED, `read_index`=0, `write_en`=0, `write_address`=9'h100, `write_sample`=0, `armed`=1, offset 0, timeout count 0, `prev_neg`=0.
- Reset mid-capture aborts the capture. The partially written half stays undisplayed, because `read_index` returns to 0 and writes restart at 9'h100.

## Structure
- Shared package `wave_pkg`:
  - State encoding constants ARMED/ACTIVE/WAIT.
  - `WAVE_SAMPLES`=256.
  - `WAVE_ADDR_W`=9.
  - `WAVE_DATA_W`=8.
- Sub-module `zero_cross_det`: holds `prev_neg` and outputs a combinational `rising` flag for the current strobe.
- All other state (FSM, offset, timeout counter, output registers) lives in `wave_buffer_ctrl`, built on the codebase's resettable flop cells.

## Test plan
- Reset, then samples -100, 50 (as `sample_in[15:8]`) → no write for -100. 50 triggers: write at 9'h100 with data 77, state ACTIVE.
- After that trigger, 255 more strobes with `s`=0 → writes at 9'h101..9'h1FF with data 127. State WAIT; further strobes produce no writes.
- In WAIT, pulse `vsync` → `read_index`=1 next cycle, `armed`=1. The next trigger writes at 9'h000.
- ARMED with all-positive input (`s`=20), `TRIG_TIMEOUT`=1024 → no writes for 1023 samples. The 1024th is written at offset 0 with data 107.
- `vsync` during ACTIVE at offset 100 → `read_index` unchanged, capture continues. Simultaneous `vsync` + `new_sample` in WAIT → flip, no write.
- Assert `reset` at ACTIVE offset 130 with `read_index`=1 → immediately `read_index`=0, `write_en`=0, `write_address`=9'h100, `armed`=1.
